branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 5-stage RV32I pipeline, the prediction-side counterpart of the execute-stage branch comparator. In fetch it supplies a predicted next PC from a direct-mapped branch history/target table. In execute it takes the comparator's resolved outcome, flags a misprediction with the correct redirect PC, and trains the table. It also keeps saturating branch and mispredict counters that are readable over the UART debug path.

## Interface
- IDX_BITS, 5, log2 of table entries (32 entries); index is pc[IDX_BITS+1:2]
- TAG_BITS, 30-IDX_BITS, derived localparam; tag is pc[31:IDX_BITS+2]
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_f  in  32  fetch PC
- npc_pred_f  out  32  predicted next fetch PC
- pred_taken_f  out  1  prediction; the pipeline carries it to execute
- resolve_valid_e  in  1  conditional branch in execute this cycle; low for bubbles and flushed slots
- pc_e  in  32  PC of the resolving branch
- br_taken_e  in  1  resolved outcome from the branch comparator
- target_e  in  32  computed branch target
- pred_taken_e  in  1  prediction made for this branch in fetch
- pred_npc_e  in  32  predicted next PC made for this branch in fetch
- mispredict_e  out  1  flush IF/ID and redirect fetch
- redirect_pc_e  out  32  correct next PC
- stats_clr  in  1  synchronous clear of the statistics counters
- branch_cnt  out  32  resolved branches, saturating
- mispred_cnt  out  32  mispredictions, saturating

## Operation
- Per-entry state: valid, tag[TAG_BITS], target[32], ctr[2]. The 2-bit saturating counter encodes 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup (combinational):
  - hit = valid & (tag == pc_f tag).
  - pred_taken_f = hit & ctr[1].
  - npc_pred_f = pred_taken_f ? target : pc_f+4.
- Resolve (combinational, gated by resolve_valid_e):
  - actual_npc = br_taken_e ? target_e : pc_e+4.
  - mispredict_e = resolve_valid_e & (actual_npc != pred_npc_e).
  - redirect_pc_e = actual_npc.
  - When resolve_valid_e=0: mispredict_e=0 and redirect_pc_e=pc_e+4.
- Training on the clock edge when resolve_valid_e=1. "Hit" here means a tag match at index(pc_e).
  - Hit: ctr increments on taken and decrements on not-taken, saturating at 11 and 00. If taken, target <= target_e.
  - Miss, taken: allocate. valid=1, tag=tag(pc_e), target=target_e, ctr=10 (WT). Any previous occupant is replaced.
  - Miss, not-taken: no change.
- Statistics, on the clock edge:
  - branch_cnt increments when resolve_valid_e=1.
  - mispred_cnt increments when mispredict_e=1.
  - Both hold at 32'hFFFF_FFFF instead of wrapping.
  - stats_clr=1 forces both to 0 and takes priority over a same-cycle increment.
- Arithmetic: pc+4 is modulo 2^32. The table ignores pc[1:0].

## Timing
- Reset (rst_n=0, async): all valid=0, all ctr=01, branch_cnt=0, mispred_cnt=0.
  - Consequence: pred_taken_f=0 and npc_pred_f=pc_f+4.
  - Tags and targets are not reset; they are don't-care while valid=0.
- Lookup and resolve outputs are zero-latency combinational.
- A table write becomes visible to fetch the cycle after the training edge.
- Same-index read/write in one cycle: fetch sees the pre-update entry (no bypass).
- Reset asserted mid-training: the pending write is discarded and the table is in its reset state.
- No back-pressure and no handshake. The pipeline guarantees at most one resolve per cycle and drops resolve_valid_e for stalled, repeated execute cycles.

## Structure
- Shared pipeline_pkg holds:
  - the counter enum bp_ctr_t with SNT/WNT/WT/ST;
  - function bp_ctr_next(bp_ctr_t c, logic taken) for the saturating update;
  - the default IDX_BITS.
- No sub-module. The table is flop arrays inside one always_ff with async reset. A RAM macro is not allowed because valid must reset.

## Test plan
- Reset, then pc_f=0x100 -> pred_taken_f=0, npc_pred_f=0x104, branch_cnt=0, mispred_cnt=0.
- Resolve pc_e=0x100, taken, target_e=0x40, pred_npc_e=0x104 -> mispredict_e=1, redirect_pc_e=0x40. Next cycle pc_f=0x100 gives pred_taken_f=1, npc_pred_f=0x40, and mispred_cnt=1.
- Resolve 0x100 not-taken twice (pred_npc_e=0x40 each) -> both cycles mispredict_e=1, redirect_pc_e=0x104. ctr goes 10->01->00 and pred_taken_f drops after the first resolve.
- Aliasing: 0x100 is allocated taken, then 0x180 (same index at IDX_BITS=5) resolves taken to 0x200 -> entry replaced. pc_f=0x100 now misses and predicts 0x104.
- Same-cycle resolve and lookup on 0x100 -> npc_pred_f reflects the old entry, the new value appears next cycle. Also: stats_clr together with a mispredict gives both counters 0.
- Force mispred_cnt to 32'hFFFF_FFFF (backdoor), then mispredict -> count stays at 32'hFFFF_FFFF. Async rst_n pulse mid-cycle -> outputs reset immediately without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
package branch_predictor_pkg;

  // Default log2 of the number of predictor table entries.
  localparam int BP_IDX_BITS = 5;

  // 2-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // Saturating counter update: step towards ST on taken, towards SNT otherwise.
  function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic taken);
    bp_ctr_t n;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

  // 32-bit increment that holds at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped branch history/target table: fetch-side lookup, execute-side
// mispredict detection and training, plus saturating branch statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic [31:0] npc_pred_f,
  output logic        pred_taken_f,
  input  logic        resolve_valid_e,
  input  logic [31:0] pc_e,
  input  logic        br_taken_e,
  input  logic [31:0] target_e,
  input  logic        pred_taken_e,
  input  logic [31:0] pred_npc_e,
  output logic        mispredict_e,
  output logic [31:0] redirect_pc_e,
  input  logic        stats_clr,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int ENTRIES  = 1 << IDX_BITS;

  // Table state (tags and targets are meaningless while valid is low)
  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  bp_ctr_t             ctr_q    [ENTRIES];
  bp_ctr_t             ctr_d    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0] tag_f, tag_e;
  logic                hit_f, hit_e;
  logic [31:0]         pc_e_plus4;
  logic [31:0]         actual_npc;

  // pred_taken_e only matters to the pipeline; the mispredict decision compares
  // next PCs so a taken branch with a stale target is also caught.
  logic unused_pred_taken;
  assign unused_pred_taken = pred_taken_e;

  assign idx_f = pc_f[IDX_BITS+1:2];
  assign tag_f = pc_f[31:IDX_BITS+2];
  assign idx_e = pc_e[IDX_BITS+1:2];
  assign tag_e = pc_e[31:IDX_BITS+2];

  // Fetch lookup: predict taken only on a tag hit with a taken-leaning counter.
  always_comb begin
    hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    pred_taken_f = hit_f && ctr_q[idx_f][1];
    if (pred_taken_f) begin
      npc_pred_f = target_q[idx_f];
    end else begin
      npc_pred_f = pc_f + 32'd4;
    end
  end

  // Execute resolve: compare the true next PC against what fetch assumed.
  always_comb begin
    pc_e_plus4 = pc_e + 32'd4;
    if (br_taken_e) begin
      actual_npc = target_e;
    end else begin
      actual_npc = pc_e_plus4;
    end
    if (resolve_valid_e) begin
      mispredict_e  = (actual_npc != pred_npc_e);
      redirect_pc_e = actual_npc;
    end else begin
      mispredict_e  = 1'b0;
      redirect_pc_e = pc_e_plus4;
    end
  end

  // Training: update counter/target on a hit, allocate on a taken miss.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    if (resolve_valid_e) begin
      if (hit_e) begin
        ctr_d[idx_e] = bp_ctr_next(ctr_q[idx_e], br_taken_e);
        if (br_taken_e) begin
          target_d[idx_e] = target_e;
        end else begin
          target_d[idx_e] = target_q[idx_e];
        end
      end else if (br_taken_e) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = target_e;
        ctr_d[idx_e]    = WT;
      end else begin
        ctr_d[idx_e] = ctr_q[idx_e];
      end
    end else begin
      ctr_d[idx_e] = ctr_q[idx_e];
    end
  end

  // Statistics: clear wins over a same-cycle increment; increments saturate.
  always_comb begin
    if (stats_clr) begin
      branch_cnt_d  = 32'd0;
      mispred_cnt_d = 32'd0;
    end else begin
      branch_cnt_d  = resolve_valid_e ? sat_inc32(branch_cnt_q)  : branch_cnt_q;
      mispred_cnt_d = mispredict_e    ? sat_inc32(mispred_cnt_q) : mispred_cnt_q;
    end
  end

  // State registers; tags/targets are left out of reset since valid masks them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic [31:0] npc_pred_f;
  logic        pred_taken_f;
  logic        resolve_valid_e;
  logic [31:0] pc_e;
  logic        br_taken_e;
  logic [31:0] target_e;
  logic        pred_taken_e;
  logic [31:0] pred_npc_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
  logic        stats_clr;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int checks;
  int failures;

  branch_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_f            (pc_f),
    .npc_pred_f      (npc_pred_f),
    .pred_taken_f    (pred_taken_f),
    .resolve_valid_e (resolve_valid_e),
    .pc_e            (pc_e),
    .br_taken_e      (br_taken_e),
    .target_e        (target_e),
    .pred_taken_e    (pred_taken_e),
    .pred_npc_e      (pred_npc_e),
    .mispredict_e    (mispredict_e),
    .redirect_pc_e   (redirect_pc_e),
    .stats_clr       (stats_clr),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] pnpc);
    resolve_valid_e = 1'b1;
    pc_e            = pc;
    br_taken_e      = tk;
    target_e        = tgt;
    pred_taken_e    = ptk;
    pred_npc_e      = pnpc;
    #1;
  endtask

  task automatic idle();
    resolve_valid_e = 1'b0;
    #1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    pc_f            = 32'h100;
    resolve_valid_e = 1'b0;
    pc_e            = 32'h0;
    br_taken_e      = 1'b0;
    target_e        = 32'h0;
    pred_taken_e    = 1'b0;
    pred_npc_e      = 32'h0;
    stats_clr       = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("rst_npc", npc_pred_f, 32'h104);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    pc_f = 32'hFFFF_FFFC;
    #1;
    chk("npc_wrap", npc_pred_f, 32'h0);
    pc_f = 32'h100;

    // Taken miss allocates; fetch sees it only after the edge
    resolve(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    chk("alloc_mispredict", {31'd0, mispredict_e}, 32'd1);
    chk("alloc_redirect", redirect_pc_e, 32'h40);
    chk("alloc_same_cycle_pred", {31'd0, pred_taken_f}, 32'd0);
    tick();
    idle();
    chk("alloc_pred_taken", {31'd0, pred_taken_f}, 32'd1);
    chk("alloc_npc", npc_pred_f, 32'h40);
    chk("alloc_mispred_cnt", mispred_cnt, 32'd1);
    chk("alloc_branch_cnt", branch_cnt, 32'd1);
    chk("idle_mispredict", {31'd0, mispredict_e}, 32'd0);
    chk("idle_redirect", redirect_pc_e, 32'h104);

    // Two not-taken resolves: ctr 10 -> 01 -> 00
    resolve(32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    chk("nt1_mispredict", {31'd0, mispredict_e}, 32'd1);
    chk("nt1_redirect", redirect_pc_e, 32'h104);
    tick();
    chk("nt1_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("nt1_npc", npc_pred_f, 32'h104);
    resolve(32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    chk("nt2_mispredict", {31'd0, mispredict_e}, 32'd1);
    chk("nt2_redirect", redirect_pc_e, 32'h104);
    tick();
    chk("nt2_branch_cnt", branch_cnt, 32'd3);
    chk("nt2_mispred_cnt", mispred_cnt, 32'd3);

    // From SNT one taken only reaches WNT: still predicts not-taken
    resolve(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    chk("snt_sat_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    // Correct prediction: no mispredict, counters step branch only
    resolve(32'h100, 1'b0, 32'h40, 1'b0, 32'h104);
    chk("correct_mispredict", {31'd0, mispredict_e}, 32'd0);
    tick();
    chk("correct_branch_cnt", branch_cnt, 32'd5);
    chk("correct_mispred_cnt", mispred_cnt, 32'd4);

    // Aliasing: 0x180 shares index with 0x100 and replaces it
    resolve(32'h180, 1'b1, 32'h200, 1'b0, 32'h184);
    tick();
    idle();
    chk("alias_old_pred", {31'd0, pred_taken_f}, 32'd0);
    chk("alias_old_npc", npc_pred_f, 32'h104);
    pc_f = 32'h180;
    #1;
    chk("alias_new_pred", {31'd0, pred_taken_f}, 32'd1);
    chk("alias_new_npc", npc_pred_f, 32'h200);

    // Same-cycle lookup sees old entry; stats_clr beats the mispredict increment
    resolve(32'h180, 1'b0, 32'h200, 1'b1, 32'h200);
    stats_clr = 1'b1;
    #1;
    chk("same_mispredict", {31'd0, mispredict_e}, 32'd1);
    chk("same_redirect", redirect_pc_e, 32'h184);
    chk("same_old_npc", npc_pred_f, 32'h200);
    tick();
    stats_clr = 1'b0;
    idle();
    chk("same_new_pred", {31'd0, pred_taken_f}, 32'd0);
    chk("same_new_npc", npc_pred_f, 32'h184);
    chk("clr_branch_cnt", branch_cnt, 32'd0);
    chk("clr_mispred_cnt", mispred_cnt, 32'd0);

    // Hit taken retrains target: ctr 01 -> 10, target 0x300
    resolve(32'h180, 1'b1, 32'h300, 1'b0, 32'h184);
    tick();
    idle();
    chk("retarget_npc", npc_pred_f, 32'h300);
    chk("retarget_mispred_cnt", mispred_cnt, 32'd1);

    // Saturation of mispred_cnt
    @(negedge clk);
    dut.mispred_cnt_q = 32'hFFFF_FFFF;
    resolve(32'h180, 1'b0, 32'h300, 1'b1, 32'h300);
    chk("sat_mispredict", {31'd0, mispredict_e}, 32'd1);
    tick();
    idle();
    chk("sat_mispred_cnt", mispred_cnt, 32'hFFFF_FFFF);
    chk("sat_branch_cnt", branch_cnt, 32'd2);

    // Async reset mid-cycle, with a pending taken write that must be dropped
    pc_f = 32'h100;
    resolve(32'h100, 1'b1, 32'h500, 1'b0, 32'h104);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mispred_cnt", mispred_cnt, 32'd0);
    chk("arst_branch_cnt", branch_cnt, 32'd0);
    pc_f = 32'h180;
    #1;
    chk("arst_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("arst_npc", npc_pred_f, 32'h184);
    tick();
    idle();
    rst_n = 1'b1;
    pc_f  = 32'h100;
    #1;
    chk("arst_drop_write", npc_pred_f, 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
